// File: rtl/uart_tx_arb.sv
// uart_tx_arb: two-port byte arbiter in front of a single UART transmitter.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   reqN, dataN, lockN    port N byte request, byte, keep-ownership request
//   ackN                  one-cycle pulse when the port N byte is accepted
//   trmt, tx_data         start pulse and byte for the transmitter
//   tx_done               transmitter idle/complete flag
//   gnt                   one-hot current or last owner (2'b00 only after reset)
//   busy                  high while a byte is being handed off or transmitted
//   cnt0, cnt1            per-port count of accepted bytes, wrapping at 256
module uart_tx_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       lock0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic       lock1,
    output logic       ack1,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic [1:0] gnt,
    output logic       busy,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_ack0, r_ack1, r_trmt, r_busy;
    logic       w_ack0_nxt, w_ack1_nxt, w_trmt_nxt, w_busy_nxt;
    logic [7:0] r_tx_data, w_tx_data_nxt;
    logic [1:0] r_gnt, w_gnt_nxt;
    logic [7:0] r_cnt0, r_cnt1, w_cnt0_nxt, w_cnt1_nxt;
    logic       r_lock_hold, w_lock_hold_nxt;
    // 1 when port 1 was served last; reset value makes port 0 win the first tie.
    logic       r_last1, w_last1_nxt;

    logic       w_owner1, w_owner_lock;
    logic       w_elig0, w_elig1, w_pick1;

    // Eligibility uses the registered lock_hold: an owner dropping its lock
    // while idle releases the other port from the following cycle on, and an
    // owner that drops lock in the accept cycle still wins that accept.
    assign w_owner1     = r_gnt[1];
    assign w_owner_lock = w_owner1 ? lock1 : lock0;
    assign w_elig0      = req0 && (!r_lock_hold || !w_owner1);
    assign w_elig1      = req1 && (!r_lock_hold ||  w_owner1);
    assign w_pick1      = w_elig1 && (!w_elig0 || !r_last1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_trmt      <= 1'b0;
            r_busy      <= 1'b0;
            r_tx_data   <= '0;
            r_gnt       <= '0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
            r_lock_hold <= 1'b0;
            r_last1     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_ack0      <= w_ack0_nxt;
            r_ack1      <= w_ack1_nxt;
            r_trmt      <= w_trmt_nxt;
            r_busy      <= w_busy_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_gnt       <= w_gnt_nxt;
            r_cnt0      <= w_cnt0_nxt;
            r_cnt1      <= w_cnt1_nxt;
            r_lock_hold <= w_lock_hold_nxt;
            r_last1     <= w_last1_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ack0_nxt      = 1'b0;
        w_ack1_nxt      = 1'b0;
        w_trmt_nxt      = 1'b0;
        w_tx_data_nxt   = r_tx_data;
        w_gnt_nxt       = r_gnt;
        w_cnt0_nxt      = r_cnt0;
        w_cnt1_nxt      = r_cnt1;
        w_lock_hold_nxt = r_lock_hold;
        w_last1_nxt     = r_last1;

        case (r_state)
            IDLE: begin
                if (w_elig0 || w_elig1) begin
                    w_state_nxt = SEND;
                    w_trmt_nxt  = 1'b1;
                    w_last1_nxt = w_pick1;
                    if (w_pick1) begin
                        w_ack1_nxt      = 1'b1;
                        w_tx_data_nxt   = data1;
                        w_gnt_nxt       = 2'b10;
                        w_cnt1_nxt      = r_cnt1 + 8'd1;
                        w_lock_hold_nxt = lock1;
                    end else begin
                        w_ack0_nxt      = 1'b1;
                        w_tx_data_nxt   = data0;
                        w_gnt_nxt       = 2'b01;
                        w_cnt0_nxt      = r_cnt0 + 8'd1;
                        w_lock_hold_nxt = lock0;
                    end
                end else if (r_lock_hold && !w_owner_lock) begin
                    w_lock_hold_nxt = 1'b0;
                end
            end
            SEND: w_state_nxt = WAIT;
            WAIT: if (tx_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign trmt    = r_trmt;
    assign tx_data = r_tx_data;
    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign cnt0    = r_cnt0;
    assign cnt1    = r_cnt1;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: directed vector table plus hand-written
// sequences for round-robin, lock, reset, counter wrap and stalled transmitter.
module tb_uart_tx_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       tx_done = 1'b1;
    logic       ack0, ack1, trmt, busy;
    logic [7:0] tx_data, cnt0, cnt1;
    logic [1:0] gnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data0(data0), .lock0(lock0), .ack0(ack0),
        .req1(req1), .data1(data1), .lock1(lock1), .ack1(ack1),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
        .gnt(gnt), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    typedef struct {
        logic       rst_n, req0;
        logic [7:0] d0;
        logic       l0, req1;
        logic [7:0] d1;
        logic       l1, td;
        logic       a0, a1, t;
        logic [7:0] txd;
        logic [1:0] gnt;
        logic       b;
        logic [7:0] c0, c1;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic r, input logic q0, input logic [7:0] d0,
                                input logic l0, input logic q1, input logic [7:0] d1,
                                input logic l1, input logic td, input logic a0,
                                input logic a1, input logic t, input logic [7:0] txd,
                                input logic [1:0] g, input logic b,
                                input logic [7:0] c0, input logic [7:0] c1);
        vec_t v;
        v.rst_n = r; v.req0 = q0; v.d0 = d0; v.l0 = l0; v.req1 = q1; v.d1 = d1;
        v.l1 = l1; v.td = td; v.a0 = a0; v.a1 = a1; v.t = t; v.txd = txd;
        v.gnt = g; v.b = b; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Transmitter model: a trmt pulse starts a 20-cycle frame with tx_done low.
    bit model_on = 1'b0;
    int frame_left = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (model_on) begin
            if (trmt) begin
                check("trmt_while_tx_busy", 32'(frame_left == 0 && tx_done), 1);
                frame_left = 20;
                tx_done = 1'b0;
            end else if (frame_left > 0) begin
                frame_left--;
                if (frame_left == 0) tx_done = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        model_on = 1'b0;
        frame_left = 0;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        data0 = '0; data1 = '0;
        tx_done = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [29:0] act_v, exp_v;
        logic        order[4];
        int          n, na0, ev;

        // rst   q0  d0    l0 q1  d1    l1 td | a0 a1 t  txd   gnt b  c0 c1
        vecs[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 8'hA5, 0, 0, 8'h00, 0, 1,  1, 0, 1, 8'hA5, 1, 1, 1, 0);
        vecs[2]  = mk(1, 0, 8'hA5, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'hA5, 1, 1, 1, 0);
        vecs[3]  = mk(1, 0, 8'h00, 0, 1, 8'h3C, 0, 0,  0, 0, 0, 8'hA5, 1, 1, 1, 0);
        vecs[4]  = mk(1, 0, 8'h00, 0, 1, 8'h3C, 0, 0,  0, 0, 0, 8'hA5, 1, 1, 1, 0);
        vecs[5]  = mk(1, 0, 8'h00, 0, 1, 8'h3C, 0, 1,  0, 0, 0, 8'hA5, 1, 0, 1, 0);
        vecs[6]  = mk(1, 0, 8'h00, 0, 1, 8'h3C, 0, 1,  0, 1, 1, 8'h3C, 2, 1, 1, 1);
        vecs[7]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h3C, 2, 1, 1, 1);
        vecs[8]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h3C, 2, 0, 1, 1);
        vecs[9]  = mk(1, 1, 8'h5A, 1, 1, 8'hC3, 0, 1,  1, 0, 1, 8'h5A, 1, 1, 2, 1);
        vecs[10] = mk(1, 0, 8'h00, 1, 1, 8'hC3, 0, 1,  0, 0, 0, 8'h5A, 1, 1, 2, 1);
        vecs[11] = mk(1, 0, 8'h00, 1, 1, 8'hC3, 0, 1,  0, 0, 0, 8'h5A, 1, 0, 2, 1);
        vecs[12] = mk(1, 0, 8'h00, 1, 1, 8'hC3, 0, 1,  0, 0, 0, 8'h5A, 1, 0, 2, 1);
        vecs[13] = mk(1, 0, 8'h00, 0, 1, 8'hC3, 0, 1,  0, 0, 0, 8'h5A, 1, 0, 2, 1);
        vecs[14] = mk(1, 0, 8'h00, 0, 1, 8'hC3, 0, 1,  0, 1, 1, 8'hC3, 2, 1, 2, 2);
        vecs[15] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'hC3, 2, 1, 2, 2);
        vecs[16] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[17] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; req0 = vecs[i].req0; data0 = vecs[i].d0;
            lock0 = vecs[i].l0; req1 = vecs[i].req1; data1 = vecs[i].d1;
            lock1 = vecs[i].l1; tx_done = vecs[i].td;
            @(posedge clk);
            #1;
            act_v = {ack0, ack1, trmt, tx_data, gnt, busy, cnt0, cnt1};
            exp_v = {vecs[i].a0, vecs[i].a1, vecs[i].t, vecs[i].txd, vecs[i].gnt,
                     vecs[i].b, vecs[i].c0, vecs[i].c1};
            check($sformatf("vec%0d", i), 32'(act_v), 32'(exp_v));
        end

        // Round-robin with both ports requesting from reset, 20-cycle frames.
        do_reset();
        model_on = 1'b1;
        req0 = 1'b1; data0 = 8'h10; req1 = 1'b1; data1 = 8'h20;
        n = 0;
        for (int c = 0; c < 400 && n < 4; c++) begin
            tick();
            if (ack0 || ack1) begin
                order[n] = ack1;
                check($sformatf("rr_data%0d", n), 32'(tx_data), ack1 ? 32'h20 : 32'h10);
                n++;
            end
        end
        check("rr_accepts", 32'(n), 4);
        for (int i = 0; i < 4; i++)
            if (i < n) check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
        check("rr_counts", {16'h0, cnt0, cnt1}, 32'h0202);

        // Lock: port 0 keeps ownership, drops lock in its third accept.
        do_reset();
        model_on = 1'b1;
        req0 = 1'b1; lock0 = 1'b1; data0 = 8'h77; req1 = 1'b1; data1 = 8'h88;
        n = 0; na0 = 0;
        for (int c = 0; c < 400 && n < 4; c++) begin
            tick();
            if (ack0 || ack1) begin
                order[n] = ack1;
                n++;
            end
            if (ack0) na0++;
            lock0 = (na0 < 2);
        end
        check("lock_accepts", 32'(n), 4);
        for (int i = 0; i < 4; i++)
            if (i < n) check($sformatf("lock_order%0d", i), 32'(order[i]), (i == 3) ? 1 : 0);
        check("lock_counts", {16'h0, cnt0, cnt1}, 32'h0301);

        // Reset during WAIT.
        do_reset();
        req0 = 1'b1; data0 = 8'h11;
        ev = 0;
        for (int c = 0; c < 10 && ev == 0; c++) begin
            tick();
            if (ack0) ev = 1;
        end
        check("rstw_first_ack", 32'(ev), 1);
        req0 = 1'b0;
        tick();
        tx_done = 1'b0;
        tick();
        check("rstw_in_wait", {23'h0, busy, cnt0}, 32'h101);
        rst_n = 1'b0;
        #1;
        check("rstw_async", {20'h0, busy, ack0, ack1, trmt, gnt, cnt0, cnt1},
              32'h0);
        tick();
        check("rstw_no_pulse_in_reset", {29'h0, ack0, ack1, trmt}, 0);
        rst_n = 1'b1;
        tx_done = 1'b1;
        ev = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ack0 || ack1 || trmt) ev++;
        end
        check("rstw_no_ack_without_req", 32'(ev), 0);
        req0 = 1'b1;
        ev = 0;
        for (int c = 0; c < 10 && ev == 0; c++) begin
            tick();
            if (ack0) ev = 1;
        end
        check("rstw_new_req_ack", {23'h0, ev[0], cnt0}, 32'h101);

        // 256 accepts on port 1: cnt1 wraps, cnt0 untouched.
        do_reset();
        req1 = 1'b1; data1 = 8'h5C;
        n = 0; na0 = 0;
        for (int c = 0; c < 2000 && n < 256; c++) begin
            tick();
            if (ack0) na0++;
            if (ack1) begin
                n++;
                if (n == 255) check("wrap_cnt1_255", 32'(cnt1), 255);
            end
        end
        check("wrap_accepts", 32'(n), 256);
        check("wrap_cnt1_0", 32'(cnt1), 0);
        check("wrap_cnt0", {24'h0, cnt0} | 32'(na0), 0);

        // Transmitter never completes: no further accept.
        do_reset();
        req0 = 1'b1; data0 = 8'h42;
        ev = 0;
        for (int c = 0; c < 10 && ev == 0; c++) begin
            tick();
            if (ack0) ev = 1;
        end
        check("stall_first_ack", 32'(ev), 1);
        tx_done = 1'b0;
        req1 = 1'b1;
        n = 0; na0 = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (ack0 || ack1 || trmt) n++;
            if (!busy) na0++;
        end
        check("stall_no_pulses", 32'(n), 0);
        check("stall_busy", 32'(na0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have port clk, input, 1: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port req0, input, 1: port 0 has a byte to send; held high until ack0.
REQ-004 SHALL have port data0, input, 8: port 0 byte; stable while req0 is high.
REQ-005 SHALL have port lock0, input, 1: port 0 requests to keep ownership after its current byte.
REQ-006 SHALL have port ack0, output, 1: one-cycle pulse when the port 0 byte is accepted.
REQ-007 SHALL have ports req1, data1, lock1 and ack1, identical to REQ-003 to REQ-006, for port 1.
REQ-008 SHALL have port trmt, output, 1: one-cycle start pulse to the UART transmitter.
REQ-009 SHALL have port tx_data, output, 8: byte to the transmitter; held until the next accept.
REQ-010 SHALL have port tx_done, input, 1: transmitter idle/complete flag; high after reset, low while a frame is sent.
REQ-011 SHALL have port gnt, output, 2: one-hot current or last owner; 2'b00 only after reset.
REQ-012 SHALL have port busy, output, 1: high in states SEND and WAIT.
REQ-013 SHALL have ports cnt0 and cnt1, output, 8 each: bytes accepted per port, wrapping from 255 to 0.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, SEND, WAIT.
REQ-015 SHALL, in IDLE with an eligible request in cycle N, latch the winning byte into tx_data and set gnt at the edge ending N.
REQ-016 SHALL assert the winner's ack and trmt for exactly cycle N+1 (state SEND), with all outputs registered.
REQ-017 SHALL move SEND -> WAIT unconditionally.
REQ-018 SHALL stay in WAIT until tx_done is sampled high, then return to IDLE on the next cycle.
REQ-019 SHALL ignore req0 and req1 in SEND and WAIT; no byte is accepted twice.
REQ-020 SHALL arbitrate round-robin: with both ports requesting and no lock held, grant the port not served last.
REQ-021 SHALL break the first arbitration after reset in favour of port 0.
REQ-022 SHALL, with a single port requesting, grant that port regardless of the round-robin pointer.
REQ-023 SHALL set lock_hold at accept when the winner's lock is high, and clear it at accept when the winner's lock is low.
REQ-024 SHALL clear lock_hold in IDLE whenever the owner's lock input is low.
REQ-025 SHALL, while lock_hold is set, make only the owner eligible; the other port waits even if the owner is idle.
REQ-026 SHALL increment cnt0 or cnt1 by 1 in the accept cycle.
REQ-027 SHALL not pulse trmt or any ack in a cycle where rst_n is low.
REQ-028 SHALL treat a tx_done rising edge in SEND as no event; only tx_done sampled in WAIT ends a byte.

Reset
REQ-029 SHALL, on rst_n low, go to IDLE immediately, including mid-transfer, with no completion pulse.
REQ-030 SHALL, on rst_n low, clear ack0, ack1 and trmt to 0.
REQ-031 SHALL, on rst_n low, set tx_data to 8'h00, gnt to 2'b00, cnt0 and cnt1 to 0, lock_hold to 0 and the round-robin pointer to favour port 0.

Verification
REQ-032 SHALL cover: req0 with data0=8'hA5 alone -> ack0 and trmt high one cycle later, tx_data=8'hA5, gnt=2'b01, cnt0=1.
REQ-033 SHALL cover: req0 and req1 high together from reset, tx_done model with 20-cycle frames -> bytes issued port0, port1, port0, port1; each trmt only after tx_done returns high.
REQ-034 SHALL cover: lock0 high for 3 bytes while req1 is held -> three port 0 bytes before any ack1; lock0 low on the 3rd byte -> port 1 granted next.
REQ-035 SHALL cover: rst_n pulsed low during WAIT -> busy=0 and cnt0=cnt1=0 immediately; no ack on release until a new req.
REQ-036 SHALL cover: 256 accepts on port 1 -> cnt1 wraps to 0 and cnt0 is unchanged.
REQ-037 SHALL cover: tx_done held low indefinitely -> arbiter stays in WAIT with no further ack or trmt.
